// File: rtl/merge_input_fifo_pkg.sv
// Shared tracklet constants: merger-input FIFO sizing and merge key field position.
package merge_input_fifo_pkg;

  localparam int unsigned TRK_DATA_WIDTH  = 12;
  localparam int unsigned TRK_FIFO_DEPTH  = 16;
  localparam int unsigned TRK_AFULL_LEVEL = 12;
  localparam int unsigned TRK_KEY_MSB     = 11;
  localparam int unsigned TRK_KEY_LSB     = 6;

  // Address width able to index 'entries' words (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/merge_input_fifo_ram.sv
// Simple dual-port storage for the merger input FIFO: clocked write, unregistered read
// so the head prefetch can load the output register in the same cycle.
module merge_input_fifo_ram #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ENTRIES = 15,
  parameter int unsigned AW      = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/merge_input_fifo.sv
// First-word-fall-through FIFO feeding one merger input. The head word lives in the
// output register; the remaining DEPTH-1 words live in the RAM.
module merge_input_fifo
  import merge_input_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = TRK_DATA_WIDTH,
  parameter int unsigned DEPTH       = TRK_FIFO_DEPTH,
  parameter int unsigned AFULL_LEVEL = TRK_AFULL_LEVEL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    valid_o,
  input  logic                    read_i,
  output logic                    full,
  output logic                    afull,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned RAM_ENTRIES = DEPTH - 1;
  localparam int unsigned AW          = ptr_width(RAM_ENTRIES);
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic [AW-1:0]         wr_ptr, wr_ptr_next;
  logic [AW-1:0]         rd_ptr, rd_ptr_next;
  logic [CW-1:0]         count_next;
  logic [DATA_WIDTH-1:0] dout_next, ram_q;
  logic                  valid_next, overflow_next;
  logic                  rd_acc_c, wr_acc_c, head_only_c, bypass_c, ram_wr_c, ram_rd_c;

  // Pointers cycle over the RAM entries only, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_incr(input logic [AW-1:0] p);
    return (p == AW'(RAM_ENTRIES - 1)) ? '0 : p + AW'(1);
  endfunction

  merge_input_fifo_ram #(
    .WIDTH   (DATA_WIDTH),
    .ENTRIES (RAM_ENTRIES),
    .AW      (AW)
  ) fifo_ram (
    .clk     (clk),
    .wr_en   (ram_wr_c),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // Accept/bypass decisions and next-state for pointers, head register and count.
  always_comb begin
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    count_next    = count;
    dout_next     = dout;
    valid_next    = valid_o;
    overflow_next = overflow;

    rd_acc_c    = en && read_i && valid_o;
    wr_acc_c    = en && wr_en && (!full || rd_acc_c);
    head_only_c = (count <= CW'(1));
    // A write skips the RAM when the head register is, or is about to become, empty.
    bypass_c    = wr_acc_c && (!valid_o || (rd_acc_c && head_only_c));
    ram_wr_c    = wr_acc_c && !bypass_c;
    ram_rd_c    = rd_acc_c && !head_only_c;

    if (ram_wr_c) wr_ptr_next = ptr_incr(wr_ptr);

    if (ram_rd_c) begin
      rd_ptr_next = ptr_incr(rd_ptr);
      dout_next   = ram_q;
    end else if (bypass_c) begin
      dout_next  = din;
      valid_next = 1'b1;
    end else if (rd_acc_c) begin
      dout_next  = '1;
      valid_next = 1'b0;
    end

    if (wr_acc_c && !rd_acc_c)      count_next = count + CW'(1);
    else if (rd_acc_c && !wr_acc_c) count_next = count - CW'(1);

    if (en && wr_en && full && !rd_acc_c) overflow_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout     <= '1;
      valid_o  <= 1'b0;
      full     <= 1'b0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      dout     <= dout_next;
      valid_o  <= valid_next;
      full     <= (count_next == CW'(DEPTH));
      afull    <= (count_next >= CW'(AFULL_LEVEL));
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_merge_input_fifo.sv
// Directed bench for merge_input_fifo with default parameters (12-bit words, depth 16).
module tb_merge_input_fifo;

  logic        clk, reset, en, wr_en, read_i;
  logic [11:0] din, dout;
  logic        valid_o, full, afull, overflow;
  logic [4:0]  count;
  int          checks = 0;
  int          errors = 0;

  merge_input_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .din      (din),
    .wr_en    (wr_en),
    .dout     (dout),
    .valid_o  (valid_o),
    .read_i   (read_i),
    .full     (full),
    .afull    (afull),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; wr_en = 1'b0; read_i = 1'b0; din = '0;
    #1 reset = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (dout !== 12'hFFF) begin errors++; $display("FAIL reset_dout got %h exp fff", dout); end
    checks++; if ({full, afull, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {full, afull, overflow}); end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    din = 12'h041; wr_en = 1'b1; step(); wr_en = 1'b0;
    checks++; if ({valid_o, dout} !== {1'b1, 12'h041}) begin errors++; $display("FAIL single_head got %b/%h exp 1/041", valid_o, dout); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    read_i = 1'b1; step(); read_i = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b0, 12'hFFF, 5'd0}) begin errors++; $display("FAIL single_drain got %b/%h/%0d exp 0/fff/0", valid_o, dout, count); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [3];
    exp = '{12'h010, 12'h020, 12'h030};
    for (int i = 0; i < 3; i++) begin
      din = exp[i]; wr_en = 1'b1; step();
    end
    wr_en = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b1, 12'h010, 5'd3}) begin errors++; $display("FAIL b2b_fill got %b/%h/%0d exp 1/010/3", valid_o, dout, count); end
    read_i = 1'b1;
    for (int i = 1; i < 3; i++) begin
      step();
      checks++; if ({valid_o, dout} !== {1'b1, exp[i]}) begin errors++; $display("FAIL b2b_read%0d got %b/%h exp 1/%h", i, valid_o, dout, exp[i]); end
    end
    step(); read_i = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b0, 12'hFFF, 5'd0}) begin errors++; $display("FAIL b2b_empty got %b/%h/%0d exp 0/fff/0", valid_o, dout, count); end
  endtask

  task automatic test_same_cycle_rw();
    din = 12'h0AA; wr_en = 1'b1; step();
    checks++; if ({valid_o, dout, count} !== {1'b1, 12'h0AA, 5'd1}) begin errors++; $display("FAIL rw_setup got %b/%h/%0d exp 1/0aa/1", valid_o, dout, count); end
    din = 12'h155; read_i = 1'b1; step(); wr_en = 1'b0; read_i = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b1, 12'h155, 5'd1}) begin errors++; $display("FAIL rw_head got %b/%h/%0d exp 1/155/1", valid_o, dout, count); end
    read_i = 1'b1; step(); read_i = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rw_drain got %0d exp 0", count); end
  endtask

  task automatic test_ignored();
    read_i = 1'b1; step(); read_i = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b0, 12'hFFF, 5'd0}) begin errors++; $display("FAIL read_empty got %b/%h/%0d exp 0/fff/0", valid_o, dout, count); end
    en = 1'b0; din = 12'h321; wr_en = 1'b1; step();
    checks++; if ({valid_o, dout, count} !== {1'b0, 12'hFFF, 5'd0}) begin errors++; $display("FAIL en_low_write got %b/%h/%0d exp 0/fff/0", valid_o, dout, count); end
    en = 1'b1; din = 12'h222; step();
    en = 1'b0; din = 12'h333; read_i = 1'b1; step();
    checks++; if ({valid_o, dout, count} !== {1'b1, 12'h222, 5'd1}) begin errors++; $display("FAIL en_low_hold got %b/%h/%0d exp 1/222/1", valid_o, dout, count); end
    en = 1'b1; wr_en = 1'b0; step(); read_i = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL en_low_drain got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp;
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 12'(256 + i); step();
      if (i == 10) begin
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL afull_11 got %b exp 0", afull); end
      end
      if (i == 11) begin
        checks++; if ({afull, full} !== 2'b10) begin errors++; $display("FAIL afull_12 got %b exp 10", {afull, full}); end
      end
    end
    wr_en = 1'b0;
    checks++; if ({full, count, dout, overflow} !== {1'b1, 5'd16, 12'h100, 1'b0}) begin errors++; $display("FAIL fill16 got %b/%0d/%h/%b exp 1/16/100/0", full, count, dout, overflow); end
    din = 12'h7AA; wr_en = 1'b1; step(); wr_en = 1'b0;
    checks++; if ({overflow, full, count, dout} !== {1'b1, 1'b1, 5'd16, 12'h100}) begin errors++; $display("FAIL drop_write got %b/%b/%0d/%h exp 1/1/16/100", overflow, full, count, dout); end
    din = 12'h7BB; wr_en = 1'b1; read_i = 1'b1; step(); wr_en = 1'b0;
    checks++; if ({full, count, dout} !== {1'b1, 5'd16, 12'h101}) begin errors++; $display("FAIL full_rw got %b/%0d/%h exp 1/16/101", full, count, dout); end
    for (int k = 0; k < 15; k++) begin
      exp = (k < 14) ? 12'(258 + k) : 12'h7BB;
      step();
      checks++; if ({valid_o, dout, count, full} !== {1'b1, exp, 5'(15 - k), 1'b0}) begin errors++; $display("FAIL drain%0d got %b/%h/%0d/%b exp 1/%h/%0d/0", k, valid_o, dout, count, full, exp, 15 - k); end
    end
    step(); read_i = 1'b0;
    checks++; if ({valid_o, dout, count, overflow} !== {1'b0, 12'hFFF, 5'd0, 1'b1}) begin errors++; $display("FAIL drain_end got %b/%h/%0d/%b exp 0/fff/0/1", valid_o, dout, count, overflow); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      din = 12'(513 + i); step();
    end
    wr_en = 1'b0;
    checks++; if ({count, dout} !== {5'd9, 12'h201}) begin errors++; $display("FAIL pre_reset got %0d/%h exp 9/201", count, dout); end
    #3 reset = 1'b1;
    #1;
    checks++; if ({count, valid_o, overflow, dout, full, afull} !== {5'd0, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0}) begin errors++; $display("FAIL async_reset got %0d/%b/%b/%h exp 0/0/0/fff", count, valid_o, overflow, dout); end
    din = 12'h3C3; wr_en = 1'b1; step();
    checks++; if ({count, valid_o} !== {5'd0, 1'b0}) begin errors++; $display("FAIL write_in_reset got %0d/%b exp 0/0", count, valid_o); end
    reset = 1'b0; step(); wr_en = 1'b0;
    checks++; if ({valid_o, dout, count} !== {1'b1, 12'h3C3, 5'd1}) begin errors++; $display("FAIL post_reset got %b/%h/%0d exp 1/3c3/1", valid_o, dout, count); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_same_cycle_rw();
    test_ignored();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_input_fifo.md
MERGE_INPUT_FIFO -- requirements
Module: merge_input_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning width of one stored word (key field included).
REQ-002 SHALL have parameter DEPTH, default 16, meaning total word capacity including the presented word; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_LEVEL, default 12, meaning the occupancy at which afull asserts.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  meaning global enable; when low, no write and no read is accepted.
REQ-007 SHALL have port din  input  DATA_WIDTH  meaning write data.
REQ-008 SHALL have port wr_en  input  1  meaning write request for din this cycle.
REQ-009 SHALL have port dout  output  DATA_WIDTH  meaning presented head word, for a downstream merger input.
REQ-010 SHALL have port valid_o  output  1  meaning dout holds a valid word.
REQ-011 SHALL have port read_i  input  1  meaning downstream consumes dout this cycle (driven by the merger's outread).
REQ-012 SHALL have port full  output  1  meaning occupancy == DEPTH.
REQ-013 SHALL have port afull  output  1  meaning occupancy >= AFULL_LEVEL.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  meaning current occupancy, presented word included.
REQ-015 SHALL have port overflow  output  1  meaning sticky flag: a write was dropped.

Function
REQ-016 SHALL be first-word-fall-through: dout/valid_o are registered, and the head word is presented without any read request.
REQ-017 SHALL accept a read only when read_i && valid_o && en; read_i with valid_o low SHALL be ignored with no state change.
REQ-018 SHALL accept a write when wr_en && en && (!full || read accepted in the same cycle).
REQ-019 SHALL drop a write when wr_en && en && full && no read is accepted, and SHALL set overflow, which stays set until reset.
REQ-020 SHALL make a word written into an empty FIFO appear on dout with valid_o=1 exactly one cycle after the write edge.
REQ-021 SHALL, on an accepted read with words remaining, present the next word in FIFO order on the following edge, keeping valid_o continuously high.
REQ-022 SHALL, on an accepted read of the last word with no simultaneous write, drive valid_o=0 and dout=all ones on the following edge.
REQ-023 SHALL, on a simultaneous read and write while count==1, present the written word next cycle with valid_o held high.
REQ-024 SHALL hold dout and valid_o stable while valid_o=1 and no read is accepted.
REQ-025 SHALL update count by +1 on write only, -1 on read only, and 0 on both or neither; count SHALL never exceed DEPTH or wrap below 0.
REQ-026 SHALL wrap the storage read and write pointers modulo DEPTH-1 entries (output register holds the remaining entry).
REQ-027 SHALL derive full and afull from registered count, with no combinational path from read_i or wr_en.

Reset
REQ-028 SHALL, on reset assertion and independent of clk, clear count, pointers, valid_o, full, afull and overflow to 0 and set dout to all ones.
REQ-029 SHALL discard all stored words on reset mid-operation and accept no read or write while reset is high.
REQ-030 SHALL accept a write on the first rising edge after reset deasserts.

Structure
REQ-031 SHALL take DATA_WIDTH, DEPTH and AFULL_LEVEL defaults from the shared tracklet constants package, alongside the merger key-field MSB/LSB constants.
REQ-032 SHALL instantiate one sub-module, fifo_ram: a simple dual-port (one write, one read) synchronous RAM of DEPTH-1 words.
REQ-033 SHALL contain the pointers, occupancy counter, output register and head-prefetch control outside fifo_ram.

Verification
REQ-034 SHALL verify: write 0x041 into an empty FIFO -> next cycle valid_o=1, dout=0x041, count=1.
REQ-035 SHALL verify: write 0x010,0x020,0x030 back-to-back, then hold read_i=1 -> dout 0x010,0x020,0x030 on consecutive cycles, then valid_o=0, dout=0xFFF.
REQ-036 SHALL verify: fill to 16, then write 0x7AA alone -> word dropped, overflow=1, count=16, full=1; same cycle read+write -> accepted, count stays 16.
REQ-037 SHALL verify: count==1 with simultaneous read_i and write 0x155 -> next cycle dout=0x155, valid_o=1 without a gap.
REQ-038 SHALL verify: read_i=1 while empty, and en=0 with wr_en=1 -> no change to count, valid_o or dout.
REQ-039 SHALL verify: reset asserted mid-clock with count=9 -> immediately count=0, valid_o=0, overflow=0, dout=0xFFF; first post-reset write presented after 1 cycle.
